imm_extend_queue: RTL
=====================

# imm_extend_queue

Parametrised, buffered immediate generator for the RV32I datapath. Accepts instruction words over a valid/ready handshake, extracts and sign-extends the immediate for every base format (I, S, B, U, J, plus R as zero) to XLEN bits, and delivers results in order from a DEPTH-entry FIFO. It sits between fetch/decode and the ALU/AGU operand mux and is the team's first immediate path prepared for a pipelined core.

## Interface
- XLEN, 32, result width; legal values are 32 or 64.
- DEPTH, 2, number of output FIFO entries; must be 1 or greater.
- AUTO_DECODE, 0, selects the immediate type source: 1 derives it from inst[6:0] and ignores imm_type; 0 uses imm_type.
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  inst/imm_type are valid.
- in_ready  output  1  block can accept this cycle.
- inst  input  32  instruction word.
- imm_type  input  3  format: 000 I, 001 S, 010 R, 011 B, 100 U, 101 J, 110 Z (CSR), 111 reserved.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes head this cycle.
- ext_imm  output  XLEN  immediate at FIFO head.
- out_type  output  3  resolved format of the head entry.
- illegal  output  1  head entry had a reserved or unsupported format.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Format extraction, with s = inst[31] replicated to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}, sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R: 0.
  - Z: inst[19:15] zero-extended.
- Reserved or unsupported format: ext_imm 0, illegal 1, out_type holds the requested code. The entry is still enqueued.
- AUTO_DECODE opcode map:
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 0110011 → R.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 1110011 → Z if funct3[2] is 1 and the CSR feature is compiled in; otherwise I.
  - Any other opcode → out_type 111, illegal 1.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH) || out_ready. This allows push-while-full when a pop happens in the same cycle, including DEPTH=1.
- Simultaneous push and pop leaves count unchanged, and ordering is preserved.
- Read and write pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- When out_valid is 0, ext_imm, out_type and illegal are driven 0.

## Timing
- Reset (rst low) takes effect immediately, without waiting for a clock edge:
  - out_valid, ext_imm, out_type, illegal and count go to 0.
  - Pointers clear.
  - in_ready is held 0 while rst is low.
- in_ready is 1 on the first cycle after reset release.
- Latency is 1 cycle: an entry pushed at edge N is visible at the head after edge N when the FIFO was empty.
- There is no combinational path from inst to ext_imm.
- Throughput is one entry per cycle, sustained with out_ready held high.
- Reset asserted mid-operation discards all queued entries; nothing is replayed.

## Configuration
- IMM_EXTEND_QUEUE_CSR_EN defined:
  - imm_type 110 yields the Z format.
  - AUTO_DECODE maps CSR-immediate SYSTEM instructions to Z.
- IMM_EXTEND_QUEUE_CSR_EN undefined:
  - imm_type 110 is treated as reserved: illegal=1, ext_imm=0.
  - All SYSTEM opcodes decode as I.

## Test plan
- Formats, XLEN=32, imm_type driven, out_ready=1. Each result appears 1 cycle after push with illegal=0:
  - 0xFFF00093 with I → 0xFFFFFFFF.
  - 0xFE112E23 with S → 0xFFFFFFFC.
  - 0x123450B7 with U → 0x12345000.
  - 0xFFDFF06F with J → 0xFFFFFFFC.
- XLEN=64, AUTO_DECODE=1: inst 0xFFF00093 → ext_imm 0xFFFFFFFFFFFFFFFF, out_type 000.
- Backpressure, DEPTH=2, out_ready=0: push three back-to-back valid words.
  - in_ready drops after the second push; count=2.
  - Raise out_ready: entries drain in push order, one per cycle, and the third is accepted on the first pop cycle.
- Full push+pop, DEPTH=1: keep count at 1, then assert in_valid and out_ready together → count stays 1, and the head updates to the new word the next cycle.
- Illegal inputs:
  - imm_type 111 → illegal=1, ext_imm=0.
  - AUTO_DECODE with opcode 0x7F → out_type 111, illegal=1.
  - imm_type 110 without IMM_EXTEND_QUEUE_CSR_EN → illegal=1.
  - imm_type 110 with the macro and inst 0x0002D073 → ext_imm 0x00000005.
- Reset mid-stream: with count=2, pull rst low between clock edges → out_valid=0 and count=0 immediately. After release, in_ready=1 and no stale entry appears.

Source files
------------

// File: rtl/imm_extend_queue.sv
// RV32I immediate generator feeding a DEPTH-entry in-order FIFO toward the operand mux.
// Optional macro IMM_EXTEND_QUEUE_CSR_EN enables the Z (CSR zimm) format.
module imm_extend_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int AUTO_DECODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst,
    input  logic [2:0]                 imm_type,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            ext_imm,
    output logic [2:0]                 out_type,
    output logic                       illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    localparam logic [2:0] TYPE_I   = 3'b000;
    localparam logic [2:0] TYPE_S   = 3'b001;
    localparam logic [2:0] TYPE_R   = 3'b010;
    localparam logic [2:0] TYPE_B   = 3'b011;
    localparam logic [2:0] TYPE_U   = 3'b100;
    localparam logic [2:0] TYPE_J   = 3'b101;
    localparam logic [2:0] TYPE_Z   = 3'b110;
    localparam logic [2:0] TYPE_RSV = 3'b111;

`ifdef IMM_EXTEND_QUEUE_CSR_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    logic [2:0]      w_auto_type;
    logic [2:0]      w_type;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;

    logic [XLEN-1:0]  r_imm  [DEPTH];
    logic [2:0]       r_type [DEPTH];
    logic             r_ill  [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    always_comb begin
        w_auto_type = TYPE_RSV;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: w_auto_type = TYPE_I;
            7'b0100011:                         w_auto_type = TYPE_S;
            7'b0110011:                         w_auto_type = TYPE_R;
            7'b1100011:                         w_auto_type = TYPE_B;
            7'b0110111, 7'b0010111:             w_auto_type = TYPE_U;
            7'b1101111:                         w_auto_type = TYPE_J;
            7'b1110011:                         w_auto_type = (CSR_EN && inst[14]) ? TYPE_Z : TYPE_I;
            default:                            w_auto_type = TYPE_RSV;
        endcase
    end

    assign w_type = (AUTO_DECODE != 0) ? w_auto_type : imm_type;

    // Unsupported formats still enqueue, carrying the requested code and a zero immediate.
    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (w_type)
            TYPE_I: w_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            TYPE_S: w_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_R: w_imm = '0;
            TYPE_B: w_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            TYPE_U: begin
                w_imm       = {XLEN{inst[31]}};
                w_imm[31:0] = {inst[31:12], 12'b0};
            end
            TYPE_J: w_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            TYPE_Z: begin
                if (CSR_EN) begin
                    w_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid && ready; in_ready may
    // depend on out_ready so a full queue accepts a word in the same cycle it is popped.
    assign out_valid = (r_count != '0);
    assign in_ready  = rst && ((r_count < DEPTH_C) || out_ready);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wptr]  <= w_imm;
            r_type[r_wptr] <= w_type;
            r_ill[r_wptr]  <= w_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ext_imm  = out_valid ? r_imm[r_rptr]  : '0;
    assign out_type = out_valid ? r_type[r_rptr] : 3'b000;
    assign illegal  = out_valid ? r_ill[r_rptr]  : 1'b0;
    assign count    = r_count;

endmodule
